snitch_fpu_writeback: RTL

// - Downstream stage of the FPU wrapper: consumes its result/status/tag handshake and the FP load

---
 rtl/snitch_fpu_writeback.sv | 116 +++++++++++
 1 files changed

// File: rtl/snitch_fpu_writeback.sv
// rtl/snitch_fpu_writeback.sv - FPU/LSU writeback arbiter, integer result buffer, sticky fflags and FP scoreboard
module snitch_fpu_writeback #(
  parameter int unsigned FLEN     = 64,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NrFpRegs = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_is_int_i,
  input  logic [2:0][4:0] sb_raddr_i,
  output logic [2:0]      sb_busy_o,
  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  input  logic [5:0]      fpu_tag_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [FLEN-1:0] lsu_data_i,
  output logic            fpr_we_o,
  output logic [4:0]      fpr_waddr_o,
  output logic [FLEN-1:0] fpr_wdata_o,
  output logic            int_valid_o,
  input  logic            int_ready_i,
  output logic [4:0]      int_rd_o,
  output logic [XLEN-1:0] int_data_o,
  output logic [4:0]      fflags_o,
  input  logic            fflags_we_i,
  input  logic [4:0]      fflags_wdata_i
);

  logic [NrFpRegs-1:0] busy_q, busy_set, busy_clr;
  logic                rr_q;
  logic                int_valid_q;
  logic [4:0]          int_rd_q;
  logic [XLEN-1:0]     int_data_q;
  logic [4:0]          fflags_q, fflags_d;

  logic fpu_is_int, fpu_fp_req, lsu_req;
  logic grant_fpu, grant_lsu, fpu_accept, int_accept;

  assign fpu_is_int = fpu_tag_i[5];
  assign fpu_fp_req = fpu_valid_i & ~fpu_is_int;
  assign lsu_req    = lsu_valid_i;

  // Round-robin only matters under contention; a lone requester always wins.
  assign grant_fpu = fpu_fp_req & (~lsu_req | ~rr_q);
  assign grant_lsu = lsu_req & (~fpu_fp_req | rr_q);

  assign fpu_ready_o = fpu_is_int ? (~int_valid_q | int_ready_i) : grant_fpu;
  assign lsu_ready_o = grant_lsu;
  assign fpu_accept  = fpu_valid_i & fpu_ready_o;
  assign int_accept  = fpu_accept & fpu_is_int;

  assign fpr_we_o    = grant_fpu | grant_lsu;
  assign fpr_waddr_o = grant_lsu ? lsu_rd_i : fpu_tag_i[4:0];
  assign fpr_wdata_o = grant_lsu ? lsu_data_i : fpu_result_i;

  // WAW stall: an FP-destination issue waits until its rd has retired.
  assign issue_ready_o = issue_is_int_i | ~busy_q[issue_rd_i];

  always_comb begin
    sb_busy_o = '0;
    for (int i = 0; i < 3; i++) begin
      sb_busy_o[i] = busy_q[sb_raddr_i[i]];
    end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int unsigned r = 0; r < NrFpRegs; r++) begin
      busy_set[r] = issue_valid_i & issue_ready_o & ~issue_is_int_i & (issue_rd_i == 5'(r));
      busy_clr[r] = fpr_we_o & (fpr_waddr_o == 5'(r));
    end
  end

  // A CSR write replaces the old value but never drops a status retiring this cycle.
  assign fflags_d = (fflags_we_i ? fflags_wdata_i : fflags_q) | (fpu_accept ? fpu_status_i : 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      rr_q        <= 1'b0;
      int_valid_q <= 1'b0;
      int_rd_q    <= '0;
      int_data_q  <= '0;
      fflags_q    <= '0;
    end else begin
      busy_q   <= (busy_q & ~busy_clr) | busy_set;
      fflags_q <= fflags_d;
      if (grant_fpu && lsu_req) begin
        rr_q <= 1'b1;
      end else if (grant_lsu && fpu_fp_req) begin
        rr_q <= 1'b0;
      end
      if (int_accept) begin
        int_valid_q <= 1'b1;
        int_rd_q    <= fpu_tag_i[4:0];
        int_data_q  <= fpu_result_i[XLEN-1:0];
      end else if (int_ready_i) begin
        int_valid_q <= 1'b0;
      end
    end
  end

  assign int_valid_o = int_valid_q;
  assign int_rd_o    = int_rd_q;
  assign int_data_o  = int_data_q;
  assign fflags_o    = fflags_q;

endmodule
